// File: rtl/lr3_pkg.sv
// lr3_pkg: debounce FSM state encoding and default timing parameters
package lr3_pkg;
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} deb_state_t;
    localparam int DEB_CYCLES_DEF = 500000;
    localparam int DISP_DIV_DEF = 100000;
endpackage

// File: rtl/ce_divider.sv
// ce_divider: free-running modulo-DIV counter with a registered one-cycle CE strobe
module ce_divider
    import lr3_pkg::*;
#(
    parameter int DIV = DISP_DIV_DEF
) (
    input  logic CLK,
    input  logic RST,
    output logic CE
);
    localparam int W = $clog2(DIV);
    logic [W-1:0] cnt;
    logic last;
    assign last = cnt == W'(DIV - 1);
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
            CE <= 1'b0;
        end else begin
            cnt <= last ? '0 : cnt + 1'b1;
            CE <= last;
        end
    end
endmodule

// File: rtl/btn_disp_ce.sv
// btn_disp_ce: synchronized, debounced button press strobe plus display scan clock enable
module btn_disp_ce
    import lr3_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int DISP_DIV = DISP_DIV_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_IN,
    output logic BTN_CE,
    output logic BTN_LVL,
    output logic DISP_CE
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    if (DEB_CYCLES < 1 || DISP_DIV < 2) begin : g_bad_params
        $error("btn_disp_ce: DEB_CYCLES must be >= 1 and DISP_DIV >= 2");
    end
    logic [1:0] rst_sync;
    logic rst_i;
    logic [1:0] btn_sync;
    logic sync;
    deb_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) rst_sync <= '0;
        else rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_i = rst_sync[1];
    assign sync = btn_sync[1];
    always_ff @(posedge CLK or negedge rst_i) begin
        if (!rst_i) begin
            btn_sync <= '0;
            state <= IDLE;
            cnt <= '0;
            BTN_CE <= 1'b0;
            BTN_LVL <= 1'b0;
        end else begin
            btn_sync <= {btn_sync[0], BTN_IN};
            state <= state_n;
            cnt <= cnt_n;
            BTN_CE <= (state == IDLE || state == PRESS_WAIT) && state_n == PRESSED;
            BTN_LVL <= state_n == PRESSED || state_n == RELEASE_WAIT;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        case (state)
            IDLE: begin
                if (sync) begin
                    state_n = PRESS_WAIT;
                    cnt_n = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync) state_n = IDLE;
                else if (cnt == CNT_LAST) state_n = PRESSED;
                else cnt_n = cnt + 1'b1;
            end
            PRESSED: begin
                if (!sync) begin
                    state_n = RELEASE_WAIT;
                    cnt_n = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync) state_n = PRESSED;
                else if (cnt == CNT_LAST) state_n = IDLE;
                else cnt_n = cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
    ce_divider #(.DIV(DISP_DIV)) u_div (
        .CLK(CLK),
        .RST(rst_i),
        .CE(DISP_CE)
    );
endmodule

// File: doc/btn_disp_ce.md
BTN_DISP_CE -- requirements
Module: btn_disp_ce

Interface
REQ-001 Parameter DEB_CYCLES, default 500000, number of consecutive stable synchronized samples required to accept a press or a release (legal range >= 1).
REQ-002 Parameter DISP_DIV, default 100000, DISP_CE period in CLK cycles (legal range >= 2).
REQ-003 CLK  input  1  single system clock; all logic on rising edge.
REQ-004 RST  input  1  reset; asynchronous, active-low.
REQ-005 BTN_IN  input  1  raw mechanical button level, asynchronous to CLK, active-high.
REQ-006 BTN_CE  output  1  one-cycle strobe per accepted press; feeds the digit-entry stage.
REQ-007 BTN_LVL  output  1  debounced button level.
REQ-008 DISP_CE  output  1  one-cycle strobe every DISP_DIV cycles; feeds the display scan stage.

Function
REQ-009 BTN_IN SHALL pass through a 2-flop synchronizer; only the second flop output (SYNC) is used by any other logic.
REQ-010 The debounce FSM SHALL have exactly 4 states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-011 IDLE: SYNC=1 -> PRESS_WAIT with the debounce counter cleared; otherwise remain in IDLE.
REQ-012 PRESS_WAIT: SYNC=0 -> IDLE; counter = DEB_CYCLES-1 with SYNC=1 -> PRESSED; otherwise the counter increments.
REQ-013 PRESSED: SYNC=0 -> RELEASE_WAIT with the counter cleared; otherwise remain in PRESSED.
REQ-014 RELEASE_WAIT: SYNC=1 -> PRESSED with no new strobe; counter = DEB_CYCLES-1 with SYNC=0 -> IDLE; otherwise the counter increments.
REQ-015 BTN_CE SHALL be registered and high for exactly one cycle, in the first cycle after each IDLE/PRESS_WAIT -> PRESSED transition, and SHALL never be high otherwise.
REQ-016 Latency: with BTN_IN held high from sampling edge t0, BTN_CE SHALL be high in the cycle following edge t0+DEB_CYCLES+2.
REQ-017 A holding press SHALL produce one strobe only (no auto-repeat).
REQ-018 Bounce shorter than DEB_CYCLES samples in PRESS_WAIT or RELEASE_WAIT SHALL produce no strobe and no BTN_LVL change.
REQ-019 BTN_LVL SHALL be registered, 1 in PRESSED and RELEASE_WAIT, and 0 in IDLE and PRESS_WAIT.
REQ-020 The debounce counter width SHALL be $clog2(DEB_CYCLES+1), and the counter SHALL never wrap.
REQ-021 The DISP_CE divider SHALL be free-running 0..DISP_DIV-1 and wrap to 0.
REQ-022 DISP_CE SHALL be registered and high for one cycle when the divider equals DISP_DIV-1.
REQ-023 The first DISP_CE pulse SHALL occur in the cycle after the DISP_DIV-th rising edge following reset release.
REQ-024 The divider SHALL be independent of button activity; simultaneous BTN_CE and DISP_CE strobes are legal and both SHALL be asserted.

Reset
REQ-025 RST=0 SHALL asynchronously clear the synchronizer flops, both counters, BTN_CE, BTN_LVL and DISP_CE, and force the FSM to IDLE.
REQ-026 Reset mid-press SHALL suppress any pending strobe.
REQ-027 A button still held at reset release SHALL yield exactly one BTN_CE after a full DEB_CYCLES+2 latency.
REQ-028 Reset deassertion SHALL be synchronized internally so that all flops leave reset on the same edge.

Structure
REQ-029 Package lr3_pkg SHALL hold the FSM state enum, DEB_CYCLES_DEF and DISP_DIV_DEF.
REQ-030 The DISP_CE divider SHALL be the sub-module ce_divider (parameter DIV; ports CLK, RST, CE); the synchronizer and FSM SHALL be inline.
REQ-031 Elaboration SHALL fail for DEB_CYCLES < 1 or DISP_DIV < 2.

Verification (DEB_CYCLES=4, DISP_DIV=8, 10 ns clock)
REQ-032 Reset release, BTN_IN=0 for 40 cycles -> BTN_CE never high; DISP_CE high at cycles 8, 16, 24, 32, 40.
REQ-033 BTN_IN rising and held 20 cycles -> one BTN_CE pulse exactly 6 cycles after the first high sample; BTN_LVL rises in the same cycle.
REQ-034 BTN_IN pattern 1,0,1,1,0,1 then held -> no strobe during the bounce; one strobe 6 cycles after the final rising sample.
REQ-035 Release with 2-cycle high glitches, then a clean press -> BTN_LVL stays 1 through the glitches, then a single strobe for the new press only.
REQ-036 RST pulsed low 3 cycles after the press begins, button held -> no strobe before reset; one strobe 6 cycles after reset release; DISP_CE phase restarts.
REQ-037 Press timed so BTN_CE coincides with a DISP_CE cycle -> both outputs are high in the same cycle.
